// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer: locks onto the 1..5 stage count, decodes the
// latched opcode and issues registered per-stage datapath strobes.
module stage_sequencer #(
  parameter int OPCODE_W = 4,
  parameter int ICOUNT_W = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [2:0]          ClockCount,
  input  logic [OPCODE_W-1:0] Opcode,
  output logic [4:0]          StageEn,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                RFWrite,
  output logic                ALUSrc,
  output logic                Branch,
  output logic                IllegalOp,
  output logic                SeqError,
  output logic                Synced,
  output logic [ICOUNT_W-1:0] InstrCount
);

  typedef enum logic {UNSYNC, LOCKED} state_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic alu_src;
    logic branch;
    logic illegal;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [OPCODE_W-1:0] op);
    ctrl_t c;
    c = '0;
    if (op == OPCODE_W'(1) || op == OPCODE_W'(2)) begin
      c.reg_write = 1'b1;
    end else if (op == OPCODE_W'(3)) begin
      c.mem_read  = 1'b1;
      c.reg_write = 1'b1;
      c.alu_src   = 1'b1;
    end else if (op == OPCODE_W'(4)) begin
      c.mem_write = 1'b1;
      c.alu_src   = 1'b1;
    end else if (op == OPCODE_W'(5)) begin
      c.branch = 1'b1;
    end else if (op != OPCODE_W'(0)) begin
      c.illegal = 1'b1;  // undefined opcodes otherwise behave as NOP
    end
    return c;
  endfunction

  state_t              state, state_nx;
  logic [2:0]          prev, prev_nx, expected;
  logic [OPCODE_W-1:0] op_q, op_nx;
  logic                take;
  ctrl_t               ctl;

  logic [4:0]          stage_nx;
  logic                pc_nx, ir_nx, mr_nx, mw_nx, rf_nx, alu_nx, br_nx, ill_nx;
  logic                err_nx;
  logic [ICOUNT_W-1:0] cnt_nx;

  assign expected = (prev == 3'd5) ? 3'd1 : prev + 3'd1;
  assign take     = (state == UNSYNC) ? (ClockCount == 3'd1) : (ClockCount == expected);
  assign ctl      = decode(op_q);
  assign Synced   = (state == LOCKED);

  always_comb begin
    state_nx = state;
    prev_nx  = ClockCount;
    op_nx    = op_q;
    stage_nx = '0;
    pc_nx    = 1'b0;
    ir_nx    = 1'b0;
    mr_nx    = 1'b0;
    mw_nx    = 1'b0;
    rf_nx    = 1'b0;
    alu_nx   = 1'b0;
    br_nx    = 1'b0;
    ill_nx   = 1'b0;
    err_nx   = SeqError;
    cnt_nx   = InstrCount;
    if (take) begin
      state_nx = LOCKED;
      stage_nx = 5'(1) << (ClockCount - 3'd1);
      if (ClockCount == 3'd1) begin
        pc_nx = 1'b1;
        ir_nx = 1'b1;
        op_nx = Opcode;
      end else begin
        // control levels hold from stage 2 through stage 5
        alu_nx = ctl.alu_src;
        br_nx  = ctl.branch;
      end
      if (ClockCount == 3'd2) ill_nx = ctl.illegal;
      if (ClockCount == 3'd4) begin
        mr_nx = ctl.mem_read;
        mw_nx = ctl.mem_write;
      end
      if (ClockCount == 3'd5) begin
        rf_nx  = ctl.reg_write;
        cnt_nx = InstrCount + ICOUNT_W'(1);
      end
    end else if (state == LOCKED) begin
      // lost lock: abandon the in-flight instruction
      state_nx = UNSYNC;
      err_nx   = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= UNSYNC;
      prev       <= '0;
      op_q       <= '0;
      StageEn    <= '0;
      PCWrite    <= 1'b0;
      IRWrite    <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      RFWrite    <= 1'b0;
      ALUSrc     <= 1'b0;
      Branch     <= 1'b0;
      IllegalOp  <= 1'b0;
      SeqError   <= 1'b0;
      InstrCount <= '0;
    end else begin
      state      <= state_nx;
      prev       <= prev_nx;
      op_q       <= op_nx;
      StageEn    <= stage_nx;
      PCWrite    <= pc_nx;
      IRWrite    <= ir_nx;
      MemRead    <= mr_nx;
      MemWrite   <= mw_nx;
      RFWrite    <= rf_nx;
      ALUSrc     <= alu_nx;
      Branch     <= br_nx;
      IllegalOp  <= ill_nx;
      SeqError   <= err_nx;
      InstrCount <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios plus random stage-count traffic
// checked each cycle against an instruction-level reference model.
module tb_stage_sequencer;
  localparam int OW = 4;
  localparam int IW = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [2:0]    ClockCount;
  logic [OW-1:0] Opcode;
  logic [4:0]    StageEn;
  logic          PCWrite, IRWrite, MemRead, MemWrite, RFWrite;
  logic          ALUSrc, Branch, IllegalOp, SeqError, Synced;
  logic [IW-1:0] InstrCount;

  always #5 Clock = ~Clock;

  stage_sequencer #(.OPCODE_W(OW), .ICOUNT_W(IW)) dut (
    .Clock(Clock), .Reset(Reset), .ClockCount(ClockCount), .Opcode(Opcode),
    .StageEn(StageEn), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RFWrite(RFWrite), .ALUSrc(ALUSrc), .Branch(Branch),
    .IllegalOp(IllegalOp), .SeqError(SeqError), .Synced(Synced),
    .InstrCount(InstrCount)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: tracks lock, last count, current instruction and totals.
  bit m_locked, m_err;
  int m_prev, m_op, m_cnt;
  int e_stage;
  bit e_pc, e_ir, e_mr, e_mw, e_rf, e_alu, e_br, e_ill;

  function automatic void model(input int cc, input int op, input bit rst);
    bit ok;
    {e_pc, e_ir, e_mr, e_mw, e_rf, e_alu, e_br, e_ill} = '0;
    e_stage = 0;
    if (rst) begin
      m_locked = 0; m_err = 0; m_prev = 0; m_op = 0; m_cnt = 0;
      return;
    end
    ok = m_locked ? (cc == (m_prev % 5) + 1) : (cc == 1);
    if (!ok) begin
      if (m_locked) m_err = 1;
      m_locked = 0;
    end else begin
      m_locked = 1;
      e_stage  = 1 << (cc - 1);
      if (cc == 1) begin
        e_pc = 1; e_ir = 1; m_op = op;
      end else begin
        e_alu = (m_op == 3 || m_op == 4);
        e_br  = (m_op == 5);
      end
      if (cc == 2) e_ill = (m_op > 5);
      if (cc == 4) begin
        e_mr = (m_op == 3);
        e_mw = (m_op == 4);
      end
      if (cc == 5) begin
        e_rf  = (m_op >= 1 && m_op <= 3);
        m_cnt = (m_cnt + 1) % (1 << IW);
      end
    end
    m_prev = cc;
  endfunction

  task automatic cmp_all();
    chk("stage_en", int'(StageEn), e_stage);
    chk("pulses", int'({PCWrite, IRWrite, MemRead, MemWrite, RFWrite, IllegalOp}),
        int'({e_pc, e_ir, e_mr, e_mw, e_rf, e_ill}));
    chk("levels", int'({ALUSrc, Branch}), int'({e_alu, e_br}));
    chk("synced", int'(Synced), int'(m_locked));
    chk("seq_error", int'(SeqError), int'(m_err));
    chk("instr_count", int'(InstrCount), m_cnt);
    chk("mem_excl", int'(MemRead & MemWrite), 0);
  endtask

  task automatic step(input int cc, input int op, input bit rst);
    Reset      = rst;
    ClockCount = 3'(cc);
    Opcode     = OW'(op);
    @(posedge Clock);
    #1;
    model(cc, op, rst);
    cmp_all();
  endtask

  // one full instruction; opcode is randomised outside stage 1 on purpose
  task automatic instr(input int op);
    step(1, op, 0);
    for (int s = 2; s <= 5; s++) step(s, int'($urandom_range(0, 15)), 0);
  endtask

  initial begin
    Reset = 1'b1; ClockCount = '0; Opcode = '0;

    step(0, 0, 1);
    chk("rst_outputs", int'({StageEn, PCWrite, IRWrite, MemRead, MemWrite, RFWrite,
                             ALUSrc, Branch, IllegalOp, SeqError, Synced}), 0);
    chk("rst_count", int'(InstrCount), 0);

    instr(1);
    chk("add_count", int'(InstrCount), 1);
    instr(3);
    instr(4);
    chk("ldst_count", int'(InstrCount), 3);
    instr(9);
    chk("illegal_count", int'(InstrCount), 4);

    step(0, 0, 1);
    step(3, 0, 0); step(4, 0, 0); step(5, 0, 0);
    chk("unsync_synced", int'(Synced), 0);
    chk("unsync_err", int'(SeqError), 0);
    step(1, 1, 0);
    chk("lock_synced", int'(Synced), 1);
    chk("lock_pcwrite", int'(PCWrite), 1);
    step(2, 0, 0);
    step(4, 0, 0);
    chk("skip_err", int'(SeqError), 1);
    chk("skip_synced", int'(Synced), 0);
    step(5, 0, 0);
    step(1, 2, 0);
    chk("relock_synced", int'(Synced), 1);
    chk("relock_err_sticky", int'(SeqError), 1);
    chk("abort_count", int'(InstrCount), 0);

    step(0, 0, 1);
    for (int i = 0; i < 15; i++) instr(int'($urandom_range(0, 15)));
    chk("pre_wrap", int'(InstrCount), 15);
    instr(0);
    chk("wrap", int'(InstrCount), 0);

    step(1, 3, 0); step(2, 0, 0); step(3, 0, 0);
    step(int'($urandom_range(0, 7)), 0, 1);
    chk("mid_rst_outputs", int'({StageEn, PCWrite, IRWrite, MemRead, MemWrite, RFWrite,
                                 ALUSrc, Branch, IllegalOp, SeqError, Synced}), 0);

    for (int i = 0; i < 3000; i++) begin
      int r, cc;
      r  = int'($urandom_range(0, 99));
      cc = (m_prev % 5) + 1;
      if (r < 2)       step(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1);
      else if (r < 8)  step(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 0);
      else             step(cc, int'($urandom_range(0, 15)), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
